// File: rtl/uart_frame_sender_if.sv
// uart_frame_sender_if: payload byte stream in, UART byte handshake out, plus framer status
interface uart_frame_sender_if #(
    parameter int FIFO_DEPTH = 64
);
    logic [7:0]                  s_data;
    logic                        s_valid;
    logic                        s_ready;
    logic [7:0]                  uart_tx_data;
    logic                        uart_tx_en;
    logic                        uart_tx_done;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        busy;
    logic                        frame_done;

    modport master (
        output s_data, s_valid, uart_tx_done,
        input  s_ready, uart_tx_data, uart_tx_en, fifo_level, busy, frame_done
    );

    modport slave (
        input  s_data, s_valid, uart_tx_done,
        output s_ready, uart_tx_data, uart_tx_en, fifo_level, busy, frame_done
    );
endinterface

// File: rtl/uart_frame_sender.sv
// uart_frame_sender: buffers payload bytes and sends HDR0 HDR1 payload checksum frames to a UART transmitter
module uart_frame_sender #(
    parameter int         FIFO_DEPTH  = 64,
    parameter int         PAYLOAD_LEN = 32,
    parameter logic [7:0] HDR0        = 8'hAA,
    parameter logic [7:0] HDR1        = 8'h55
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    uart_frame_sender_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;
    localparam logic [1:0] PH_HDR0 = 2'd0, PH_HDR1 = 2'd1, PH_PAY = 2'd2, PH_CSUM = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [LW-1:0] level;
    logic [1:0]    state, phase, next_phase;
    logic [7:0]    idx, csum, head, tx_data;
    logic          tx_en, frame_done, push, pop, last_pay;

    assign head     = mem[rd_ptr];
    assign push     = bus.s_valid && bus.s_ready;
    assign pop      = state == ISSUE && phase == PH_PAY;
    assign last_pay = {1'b0, idx} + 9'd1 >= 9'(PAYLOAD_LEN);

    assign bus.s_ready      = level != LW'(FIFO_DEPTH);
    assign bus.fifo_level   = level;
    assign bus.uart_tx_data = tx_data;
    assign bus.uart_tx_en   = tx_en;
    assign bus.busy         = state != IDLE;
    assign bus.frame_done   = frame_done;

    // phase order wraps CSUM back to HDR0; payload repeats until its last byte is sent
    always_comb next_phase = phase == PH_PAY ? (last_pay ? PH_CSUM : PH_PAY) : phase + 2'd1;

    // payload storage, written on every accepted byte
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= bus.s_data;
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // frame sequencer: start only with a full payload buffered, issue one byte, wait for its tx_done
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            phase      <= PH_HDR0;
            idx        <= '0;
            csum       <= '0;
            tx_en      <= 1'b0;
            tx_data    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            tx_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= PH_HDR0;
                    idx   <= '0;
                    csum  <= '0;
                    if (level >= LW'(PAYLOAD_LEN)) state <= ISSUE;
                end
                ISSUE: begin
                    tx_en   <= 1'b1;
                    tx_data <= phase == PH_HDR0 ? HDR0 : phase == PH_HDR1 ? HDR1 : phase == PH_PAY ? head : csum;
                    if (phase == PH_PAY) csum <= csum + head;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.uart_tx_done) begin
                        state      <= phase == PH_CSUM ? IDLE : ISSUE;
                        frame_done <= phase == PH_CSUM;
                        phase      <= next_phase;
                        if (phase == PH_PAY) idx <= idx + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_sender.sv
// tb_uart_frame_sender: table vectors, corner sequences and random traffic against a frame-level model
module tb_uart_frame_sender;
    localparam int P = 4;
    localparam int D = 64;

    typedef struct packed {
        logic [3:0][7:0] b;
        logic [7:0]      sum;
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    uart_frame_sender_if #(.FIFO_DEPTH(D)) bus ();

    uart_frame_sender #(
        .FIFO_DEPTH (D),
        .PAYLOAD_LEN(P),
        .HDR0       (8'hAA),
        .HDR1       (8'h55)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    int errs = 0, checks = 0;
    int cyc = 0, cnt = 0, pos = 0, last_done = 0, last_gap = 0;
    int fd_cnt = 0, en_cnt = 0, n_pop = 0, n_push = 0;
    logic tx_hold = 1'b0, spur = 1'b0, tx_done_m = 1'b0;
    logic [7:0] rx[$];
    logic [7:0] pushed[$];

    assign bus.uart_tx_done = tx_done_m | spur;
    wire is_pay = bus.uart_tx_en && pos >= 2 && pos <= P + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // transmitter model with random byte time, plus line capture and continuous occupancy checks
    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        tx_done_m <= 1'b0;
        if (sys_rst) begin
            cnt <= 0;
            pos <= 0;
            n_pop <= 0;
            rx.delete();
        end else begin
            chk("fifo_level", int'(bus.fifo_level), n_push - n_pop - int'(is_pay));
            chk("s_ready", int'(bus.s_ready), int'(n_push - n_pop - int'(is_pay) != D));
            if (is_pay) n_pop <= n_pop + 1;
            if (bus.frame_done) begin
                fd_cnt <= fd_cnt + 1;
                chk("frame_done_latency", cyc - last_done, 1);
                chk("frame_done_position", pos, 0);
            end
            if (bus.uart_tx_en) begin
                en_cnt <= en_cnt + 1;
                rx.push_back(bus.uart_tx_data);
                chk("en_overlap", cnt, 0);
                if (pos != 0) chk("byte_gap", cyc - last_done, 2);
                else last_gap <= cyc - last_done;
                cnt <= int'($urandom_range(1, 5));
                pos <= (pos == P + 2) ? 0 : pos + 1;
            end else if (cnt == 1 && !tx_hold) begin
                tx_done_m <= 1'b1;
                cnt <= 0;
                last_done <= cyc;
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        n_push = 0;
        pushed.delete();
    endtask

    task automatic push(input logic [7:0] b, input int budget, output bit ok);
        @(negedge sys_clk);
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        if (ok) begin
            @(posedge sys_clk);
            n_push++;
            pushed.push_back(b);
        end
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic pushb(input logic [7:0] b);
        bit ok;
        push(b, 300, ok);
        chk("push_accept", int'(ok), 1);
    endtask

    task automatic wait_fd(input int target, input int budget);
        int i = 0;
        while (fd_cnt < target && i < budget) begin
            tick(1);
            i++;
        end
        chk("frame_done_timeout", int'(fd_cnt >= target), 1);
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while ((bus.busy || bus.fifo_level >= P) && i < budget) begin
            tick(1);
            i++;
        end
        chk("drain_timeout", int'(i < budget), 1);
    endtask

    task automatic check_stream();
        logic [7:0] exp[$];
        logic [7:0] s;
        for (int f = 0; f + P <= pushed.size(); f += P) begin
            s = 8'h00;
            exp.push_back(8'hAA);
            exp.push_back(8'h55);
            for (int k = 0; k < P; k++) begin
                exp.push_back(pushed[f+k]);
                s += pushed[f+k];
            end
            exp.push_back(s);
        end
        chk("stream_len", rx.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx.size(); i++)
            chk($sformatf("stream_byte%0d", i), int'(rx[i]), int'(exp[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        logic [7:0] fexp[7];
        int fd0, r0, en0, n, bad;
        bit ok;

        vt[0].b = {8'h04, 8'h03, 8'h02, 8'h01}; vt[0].sum = 8'h0A;
        vt[1].b = {8'h03, 8'h02, 8'hFF, 8'hFF}; vt[1].sum = 8'h03;
        vt[2].b = {8'h00, 8'h00, 8'h80, 8'h80}; vt[2].sum = 8'h00;
        vt[3].b = {8'h78, 8'h56, 8'h34, 8'h12}; vt[3].sum = 8'h14;

        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        do_reset();
        tick(1);
        chk("rst_tx_en", int'(bus.uart_tx_en), 0);
        chk("rst_tx_data", int'(bus.uart_tx_data), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_level", int'(bus.fifo_level), 0);
        chk("rst_ready", int'(bus.s_ready), 1);
        chk("rst_frame_done", int'(bus.frame_done), 0);

        // table vectors: one frame each, exact bytes on the line
        for (int v = 0; v < 4; v++) begin
            fd0 = fd_cnt;
            r0  = rx.size();
            for (int k = 0; k < P; k++) pushb(vt[v].b[k]);
            wait_fd(fd0 + 1, 300);
            fexp[0] = 8'hAA;
            fexp[1] = 8'h55;
            for (int k = 0; k < P; k++) fexp[2+k] = vt[v].b[k];
            fexp[6] = vt[v].sum;
            chk($sformatf("tbl%0d_len", v), rx.size() - r0, 7);
            for (int i = 0; i < 7 && r0 + i < rx.size(); i++)
                chk($sformatf("tbl%0d_byte%0d", v, i), int'(rx[r0+i]), int'(fexp[i]));
            tick(2);
            chk($sformatf("tbl%0d_level_end", v), int'(bus.fifo_level), 0);
            chk($sformatf("tbl%0d_one_pulse", v), fd_cnt - fd0, 1);
        end

        // partial payload must not start a frame; completing it starts one promptly
        en0 = en_cnt;
        for (int k = 0; k < 3; k++) pushb(8'h10 + 8'(k));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.busy) bad++;
        end
        chk("partial_busy_cycles", bad, 0);
        chk("partial_no_en", en_cnt - en0, 0);
        pushb(8'h13);
        n = 0;
        while (en_cnt == en0 && n < 10) begin
            tick(1);
            n++;
        end
        chk("start_within_2p5_cycles", int'(n <= 3), 1);
        chk("start_byte_hdr0", int'(rx[rx.size()-1]), 8'hAA);
        wait_fd(fd_cnt + 1, 300);

        // spurious done in IDLE and in ISSUE, then two back-to-back frames
        fd0 = fd_cnt;
        en0 = en_cnt;
        @(negedge sys_clk);
        spur = 1'b1;
        @(negedge sys_clk);
        spur = 1'b0;
        tick(3);
        chk("spur_idle_busy", int'(bus.busy), 0);
        chk("spur_idle_no_en", en_cnt - en0, 0);
        for (int k = 0; k < 4; k++) pushb(8'h20 + 8'(k));
        @(negedge sys_clk);
        @(negedge sys_clk);
        spur = 1'b1;
        @(negedge sys_clk);
        spur = 1'b0;
        for (int k = 0; k < 4; k++) pushb(8'hE0 + 8'(k));
        wait_fd(fd0 + 2, 600);
        tick(10);
        chk("b2b_frame_count", fd_cnt - fd0, 2);
        chk("b2b_frame_gap", int'(last_gap <= 3), 1);

        // random traffic with random transmitter byte times
        for (int k = 0; k < 6 * P; k++) begin
            pushb(8'($urandom));
            tick(int'($urandom_range(0, 3)));
        end
        drain(3000);

        // transmitter stalled on HDR0: FIFO fills, 65th byte is held off
        tx_hold = 1'b1;
        r0 = rx.size();
        for (int k = 0; k < D; k++) pushb(8'($urandom));
        tick(2);
        chk("full_level", int'(bus.fifo_level), D);
        chk("full_ready", int'(bus.s_ready), 0);
        chk("full_busy", int'(bus.busy), 1);
        chk("full_stalled_on_hdr0", rx.size() - r0, 1);
        chk("full_hdr0_byte", int'(rx[rx.size()-1]), 8'hAA);
        push(8'h5A, 10, ok);
        chk("full_65th_held", int'(ok), 0);
        chk("full_level_held", int'(bus.fifo_level), D);
        tx_hold = 1'b0;
        push(8'h5A, 100, ok);
        chk("full_65th_accepted", int'(ok), 1);
        drain(5000);
        check_stream();

        // reset in the middle of a frame, then a clean frame
        do_reset();
        for (int k = 0; k < P; k++) pushb(8'h31 + 8'(k));
        n = 0;
        while (rx.size() < 4 && n < 200) begin
            tick(1);
            n++;
        end
        chk("midframe_reach_pay1", int'(rx.size() >= 4), 1);
        do_reset();
        tick(1);
        chk("midrst_tx_en", int'(bus.uart_tx_en), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_level", int'(bus.fifo_level), 0);
        chk("midrst_ready", int'(bus.s_ready), 1);
        fd0 = fd_cnt;
        for (int k = 0; k < P; k++) pushb(8'hC0 + 8'(k));
        wait_fd(fd0 + 1, 300);
        check_stream();

        tick(5);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
